intdiv_seqdiv: RTL and testbench

INTDIV_SEQDIV -- requirements
Module: intdiv_seqdiv

---
 rtl/intdiv_pkg.sv | 15 +
 rtl/intdiv_divstep.sv | 23 ++
 rtl/intdiv_seqdiv.sv | 139 +++++++++++++
 tb/tb_intdiv_seqdiv.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/intdiv_pkg.sv
// Shared FSM state encodings and named polarity constants for the sequential divider.
package intdiv_pkg;
    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t PREP = 3'd1;
    localparam state_t ITER = 3'd2;
    localparam state_t FIX  = 3'd3;
    localparam state_t DONE = 3'd4;

    localparam logic ON       = 1'b1;
    localparam logic OFF      = 1'b0;
    localparam logic NEGATIVE = 1'b1;
    localparam logic POSITIVE = 1'b0;
endpackage

// File: rtl/intdiv_divstep.sv
// One combinational non-restoring division step on an (N+1)-bit partial remainder.
module intdiv_divstep
    import intdiv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]   p,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   p_next,
    output logic [N-1:0] q_next
);
    logic [N:0] shifted;
    logic [N:0] dext;

    always_comb begin
        shifted = {p[N-1:0], q[N-1]};
        dext    = {1'b0, d};
        // Sign of the running remainder picks add or subtract; wrap in N+1 bits is harmless.
        p_next  = (p[N] == NEGATIVE) ? shifted + dext : shifted - dext;
        q_next  = {q[N-2:0], ~p_next[N]};
    end
endmodule

// File: rtl/intdiv_seqdiv.sv
// Multi-cycle signed/unsigned integer divider, STEPS quotient bits per clock.
// Optional divide-by-zero detection with output dbz under INTDIV_DIVZERO_EN.
module intdiv_seqdiv
    import intdiv_pkg::*;
#(
    parameter int N     = 8,
    parameter int STEPS = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sgn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic [N-1:0] r
`ifdef INTDIV_DIVZERO_EN
    ,
    output logic         dbz
`endif
);
    localparam int ITERS = N / STEPS;
    localparam int CW    = $clog2(ITERS + 1);

    state_t         state;
    logic [N-1:0]   xr, yr;
    logic           sr;
    logic [N:0]     pr;
    logic [N-1:0]   qr, dr;
    logic           zneg, rneg;
    logic [CW-1:0]  cnt;

    logic [STEPS:0][N:0]   p_ch;
    logic [STEPS:0][N-1:0] q_ch;
    logic [N:0]            rem_fix;
    logic [N-1:0]          z_fix, r_fix;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic s);
        return (s && v[N-1]) ? -v : v;
    endfunction

    assign in_ready = (state == IDLE);

    assign p_ch[0] = pr;
    assign q_ch[0] = qr;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        intdiv_divstep #(.N(N)) u_step (
            .p      (p_ch[g]),
            .q      (q_ch[g]),
            .d      (dr),
            .p_next (p_ch[g+1]),
            .q_next (q_ch[g+1])
        );
    end

    always_comb begin
        rem_fix = (pr[N] == NEGATIVE) ? pr + {1'b0, dr} : pr;
        z_fix   = zneg ? -qr : qr;
        r_fix   = rneg ? -rem_fix[N-1:0] : rem_fix[N-1:0];
    end

    // Datapath: operands are captured at accept so later input changes cannot leak in.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: if (in_valid) begin
                xr <= x;
                yr <= y;
                sr <= sgn;
            end
            PREP: begin
                qr   <= mag(xr, sr);
                dr   <= mag(yr, sr);
                pr   <= '0;
                zneg <= sr & (xr[N-1] ^ yr[N-1]);
                rneg <= sr & xr[N-1];
                cnt  <= '0;
            end
            ITER: begin
                pr  <= p_ch[STEPS];
                qr  <= q_ch[STEPS];
                cnt <= cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= OFF;
            z         <= '0;
            r         <= '0;
`ifdef INTDIV_DIVZERO_EN
            dbz       <= OFF;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) state <= PREP;
                PREP: begin
`ifdef INTDIV_DIVZERO_EN
                    state <= (yr == '0) ? DONE : ITER;
`else
                    state <= ITER;
`endif
                end
                ITER: if (cnt == CW'(ITERS - 1)) state <= FIX;
                FIX: begin
                    z         <= z_fix;
                    r         <= r_fix;
                    out_valid <= ON;
                    state     <= DONE;
`ifdef INTDIV_DIVZERO_EN
                    dbz       <= OFF;
`endif
                end
                DONE: begin
`ifdef INTDIV_DIVZERO_EN
                    // Divide-by-zero arrives from PREP with outputs not yet loaded.
                    if (!out_valid) begin
                        z         <= '1;
                        r         <= xr;
                        dbz       <= ON;
                        out_valid <= ON;
                    end else
`endif
                    if (out_ready) begin
                        out_valid <= OFF;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intdiv_seqdiv.sv
// Random + directed bench for intdiv_seqdiv (N=8) with STEPS=1 and STEPS=4 instances side by side.
module tb_intdiv_seqdiv;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       sgn = 1'b0;
    logic       out_ready = 1'b1;
    logic       ir1, ov1, ir4, ov4;
    logic [7:0] z1, r1, z4, r4;
`ifdef INTDIV_DIVZERO_EN
    logic       dbz1, dbz4;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    intdiv_seqdiv #(.N(8), .STEPS(1)) u_dut1 (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .x(x), .y(y), .sgn(sgn), .out_valid(ov1), .out_ready(out_ready),
        .z(z1), .r(r1)
`ifdef INTDIV_DIVZERO_EN
        , .dbz(dbz1)
`endif
    );

    intdiv_seqdiv #(.N(8), .STEPS(4)) u_dut4 (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
        .x(x), .y(y), .sgn(sgn), .out_valid(ov4), .out_ready(out_ready),
        .z(z4), .r(r4)
`ifdef INTDIV_DIVZERO_EN
        , .dbz(dbz4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, which truncates toward zero.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] ez, output logic [7:0] er);
        int ai, bi;
        if (s) begin
            ai = $signed(a);
            bi = $signed(b);
        end else begin
            ai = a;
            bi = b;
        end
        if (bi == 0) begin
            ez = 8'hFF;
            er = a;
        end else begin
            ez = 8'(ai / bi);
            er = 8'(ai % bi);
        end
    endfunction

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s);
        int l1, l4, el1, el4;
        logic [7:0] gz1, gr1, gz4, gr4, ez, er;
        logic zero, gd1, gd4;
        l1 = -1; l4 = -1;
        gz1 = 'x; gr1 = 'x; gz4 = 'x; gr4 = 'x; gd1 = 'x; gd4 = 'x;
        @(negedge clk);
        x = a; y = b; sgn = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 8'($urandom); y = 8'($urandom); sgn = 1'($urandom);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (ov1 && l1 < 0) begin
                l1 = c; gz1 = z1; gr1 = r1;
`ifdef INTDIV_DIVZERO_EN
                gd1 = dbz1;
`endif
            end
            if (ov4 && l4 < 0) begin
                l4 = c; gz4 = z4; gr4 = r4;
`ifdef INTDIV_DIVZERO_EN
                gd4 = dbz4;
`endif
            end
        end
        model(a, b, s, ez, er);
        zero = (b == 8'd0);
`ifdef INTDIV_DIVZERO_EN
        el1 = zero ? 2 : 10;
        el4 = zero ? 2 : 4;
`else
        el1 = 10;
        el4 = 4;
`endif
        chk("lat1", l1, el1);
        chk("lat4", l4, el4);
`ifdef INTDIV_DIVZERO_EN
        chk("dbz1", {31'd0, gd1}, {31'd0, zero});
        chk("dbz4", {31'd0, gd4}, {31'd0, zero});
        if (1'b1) begin
`else
        if (!zero) begin
`endif
            chk("z1", {24'd0, gz1}, {24'd0, ez});
            chk("r1", {24'd0, gr1}, {24'd0, er});
            chk("z4", {24'd0, gz4}, {24'd0, ez});
            chk("r4", {24'd0, gr4}, {24'd0, er});
        end
    endtask

    initial begin
        logic [7:0] ez, er, hz, hr;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir1", {31'd0, ir1}, 32'd1);
        chk("rst_ov1", {31'd0, ov1}, 32'd0);
        chk("rst_z1",  {24'd0, z1},  32'd0);
        chk("rst_r1",  {24'd0, r1},  32'd0);
        chk("rst_ir4", {31'd0, ir4}, 32'd1);
        chk("rst_ov4", {31'd0, ov4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(8'd7,   8'd3,   1'b1);
        run(8'hF3,  8'd4,   1'b1);
        run(8'h80,  8'hFF,  1'b1);
        run(8'd200, 8'd7,   1'b0);
        run(8'h5A,  8'd0,   1'b0);
        run(8'hFF,  8'd1,   1'b0);
        run(8'h80,  8'h80,  1'b1);

        // Stall in DONE: outputs must hold and new requests must be ignored.
        @(negedge clk);
        x = 8'd7; y = 8'd3; sgn = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge clk); #1;
            if (ov1) seen = 1;
        end
        chk("stall_seen", seen, 1);
        hz = z1; hr = r1;
        model(8'd7, 8'd3, 1'b1, ez, er);
        chk("stall_z", {24'd0, hz}, {24'd0, ez});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 8'($urandom); y = 8'($urandom); sgn = 1'($urandom);
            @(posedge clk); #1;
            chk("stall_ov", {31'd0, ov1}, 32'd1);
            chk("stall_ir", {31'd0, ir1}, 32'd0);
            chk("stall_zh", {24'd0, z1},  {24'd0, ez});
            chk("stall_rh", {24'd0, r1},  {24'd0, er});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drop_ov", {31'd0, ov1}, 32'd0);
        chk("drop_ir", {31'd0, ir1}, 32'd1);
        @(posedge clk); #1;
        chk("drop_ir4", {31'd0, ir4}, 32'd1);

        // Reset during the third ITER cycle aborts the operation.
        @(negedge clk);
        x = 8'd100; y = 8'd9; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ir", {31'd0, ir1}, 32'd1);
        chk("mid_rst_ov", {31'd0, ov1}, 32'd0);
        chk("mid_rst_z",  {24'd0, z1},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(8'd100, 8'd9, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = 8'h80;
            run(a, b, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
